// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell is reused for every bit, LSB first,
// with the carry held in a register between bits.

module full_adder (
    input  logic a0,
    input  logic a1,
    input  logic c0,
    output logic s,
    output logic c1
);
    assign s  = a0 ^ a1 ^ c0;
    assign c1 = (a0 & a1) | (a0 & c0) | (a1 & c0);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_s, fa_c1;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a0 (a_reg[0]),
        .a1 (b_reg[0]),
        .c0 (carry),
        .s  (fa_s),
        .c1 (fa_c1)
    );

    // A new operation may begin from IDLE or straight out of DONE.
    assign accept   = start && (state == IDLE || state == DONE);
    assign last_bit = (count == LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (last_bit) next_state = DONE;
            DONE: next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter stops at WIDTH-1 so it never wraps within an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            sum   <= {fa_s, sum[WIDTH-1:1]};
            carry <= fa_c1;
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            if (last_bit) cout  <= fa_c1;
            else          count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) using a result scoreboard.

module tb_serial_adder_ctrl;
    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    int passed = 0;
    int total  = 0;
    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic push_expected(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] r;
        exp_t e;
        r = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
        e.sum  = r[7:0];
        e.cout = r[8];
        sb.push_back(e);
    endtask

    task automatic pop_expected(output exp_t e, output bit ok);
        ok = (sb.size() > 0);
        if (ok) e = sb.pop_front();
        else    e = '0;
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        @(posedge clk); #1;
        a = av; b = bv; cin = cv; start = 1'b1;
        push_expected(av, bv, cv);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Samples at negedges until done; cycles is the negedge index of done, -1 on timeout.
    task automatic wait_done(output int cycles, output int busy_cycles, output bit overlap);
        cycles = -1;
        busy_cycles = 0;
        overlap = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cycles++;
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (sum !== 8'h00) $display("[TB] FAIL reset_sum got=%h exp=00", sum); else passed++;
        total++; if (cout !== 1'b0) $display("[TB] FAIL reset_cout got=%b exp=0", cout); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc, bcyc;
        bit ov, ok;
        exp_t e;
        start_op(8'h5A, 8'h3C, 1'b0);
        wait_done(cyc, bcyc, ov);
        pop_expected(e, ok);
        total++; if (cyc !== 9) $display("[TB] FAIL basic_latency got=%0d exp=9", cyc); else passed++;
        total++; if (bcyc !== 8) $display("[TB] FAIL basic_busy_cycles got=%0d exp=8", bcyc); else passed++;
        total++; if (ov !== 1'b0) $display("[TB] FAIL basic_busy_done_overlap got=%b exp=0", ov); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL basic_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL basic_cout got=%b exp=%b", cout, e.cout); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse got=%b exp=0", done); else passed++;
    endtask

    task automatic test_carry;
        int cyc, bcyc;
        bit ov, ok;
        exp_t e;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(cyc, bcyc, ov);
        pop_expected(e, ok);
        total++; if (cyc !== 9) $display("[TB] FAIL carry1_latency got=%0d exp=9", cyc); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL carry1_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL carry1_cout got=%b exp=%b", cout, e.cout); else passed++;
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc, bcyc, ov);
        pop_expected(e, ok);
        total++; if (cyc !== 9) $display("[TB] FAIL carry2_latency got=%0d exp=9", cyc); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL carry2_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL carry2_cout got=%b exp=%b", cout, e.cout); else passed++;
    endtask

    task automatic test_ignore_start;
        int cyc, bcyc, extra;
        bit ov, ok;
        exp_t e;
        start_op(8'h12, 8'h34, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bcyc, ov);
        pop_expected(e, ok);
        total++; if (cyc !== 6) $display("[TB] FAIL ignore_latency got=%0d exp=6", cyc); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL ignore_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL ignore_cout got=%b exp=%b", cout, e.cout); else passed++;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) $display("[TB] FAIL ignore_extra_activity got=%0d exp=0", extra); else passed++;
    endtask

    task automatic test_reset_mid;
        int cyc, bcyc, extra;
        bit ov, ok;
        exp_t e;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL abort_done got=%b exp=0", done); else passed++;
        total++; if (sum !== 8'h00) $display("[TB] FAIL abort_sum got=%h exp=00", sum); else passed++;
        total++; if (cout !== 1'b0) $display("[TB] FAIL abort_cout got=%b exp=0", cout); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) $display("[TB] FAIL abort_no_done got=%0d exp=0", extra); else passed++;
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(cyc, bcyc, ov);
        pop_expected(e, ok);
        total++; if (cyc !== 9) $display("[TB] FAIL after_abort_latency got=%0d exp=9", cyc); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL after_abort_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL after_abort_cout got=%b exp=%b", cout, e.cout); else passed++;
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc;
        bit ov, ok;
        exp_t e;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        push_expected(8'h10, 8'h20, 1'b0);
        @(posedge clk); #1;
        wait_done(cyc, bcyc, ov);
        pop_expected(e, ok);
        total++; if (cyc !== 9) $display("[TB] FAIL b2b_first_latency got=%0d exp=9", cyc); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL b2b_first_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL b2b_first_cout got=%b exp=%b", cout, e.cout); else passed++;
        a = 8'h80; b = 8'h80;
        push_expected(8'h80, 8'h80, 1'b0);
        wait_done(cyc, bcyc, ov);
        start = 1'b0;
        pop_expected(e, ok);
        total++; if (cyc !== 9) $display("[TB] FAIL b2b_spacing got=%0d exp=9", cyc); else passed++;
        total++; if (bcyc !== 8) $display("[TB] FAIL b2b_busy_cycles got=%0d exp=8", bcyc); else passed++;
        total++; if (ov !== 1'b0) $display("[TB] FAIL b2b_overlap got=%b exp=0", ov); else passed++;
        total++; if (!ok || sum !== e.sum) $display("[TB] FAIL b2b_second_sum got=%h exp=%h", sum, e.sum); else passed++;
        total++; if (!ok || cout !== e.cout) $display("[TB] FAIL b2b_second_cout got=%b exp=%b", cout, e.cout); else passed++;
    endtask

    task automatic test_hold;
        int bad_sum, bad_cout, bad_busy, bad_done;
        bad_sum = 0; bad_cout = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (sum !== 8'h00) bad_sum++;
            if (cout !== 1'b1) bad_cout++;
            if (busy !== 1'b0) bad_busy++;
            if (done !== 1'b0) bad_done++;
        end
        total++; if (bad_sum !== 0) $display("[TB] FAIL hold_sum bad_cycles=%0d exp=0 last_sum=%h", bad_sum, sum); else passed++;
        total++; if (bad_cout !== 0) $display("[TB] FAIL hold_cout bad_cycles=%0d exp=0 last_cout=%b", bad_cout, cout); else passed++;
        total++; if (bad_busy !== 0) $display("[TB] FAIL hold_busy bad_cycles=%0d exp=0", bad_busy); else passed++;
        total++; if (bad_done !== 0) $display("[TB] FAIL hold_done bad_cycles=%0d exp=0", bad_done); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_hold;
        total++;
        if (sb.size() !== 0) $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
